// File: rtl/mod_exp_pkg.sv
// Shared types and constants for the square-and-multiply exponentiation sequencer.
package mod_exp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    ISSUE,
    WAIT,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    TOBASE,
    TOONE,
    SQR,
    MUL,
    FROM
  } op_e;

  // Plain integer one; widened to the operand width wherever it is used.
  localparam logic MM_ONE = 1'b1;

endpackage

// File: rtl/mod_exp_ctrl.sv
// Sequences base^exp mod n through an external Montgomery multiplier using a
// left-to-right square-and-multiply schedule over the latched operands.
module mod_exp_ctrl
  import mod_exp_pkg::*;
#(
  parameter int unsigned WIDTH = 2048,
  parameter int unsigned EXP_W = 2048
) (
  input  logic             clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [EXP_W-1:0] exp,
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] r2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] mm_x,
  output logic [WIDTH-1:0] mm_y,
  output logic [WIDTH-1:0] mm_n,
  output logic             mm_rst,
  input  logic             mm_finish,
  input  logic [WIDTH-1:0] mm_result
);

  localparam int unsigned IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(EXP_W - 1);
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(MM_ONE);

  state_e           r_state, w_next;
  op_e              r_op, w_op;
  logic [IDX_W-1:0] r_idx, w_idx;
  logic [IDX_W-1:0] r_top, w_top;
  logic             r_zero, w_zero;
  logic [EXP_W-1:0] r_exp, w_exp;
  logic [WIDTH-1:0] r_base, w_base;
  logic [WIDTH-1:0] r_r2, w_r2;
  logic [WIDTH-1:0] r_n, w_n;
  logic [WIDTH-1:0] r_abar, w_abar;
  logic [WIDTH-1:0] r_acc, w_acc;
  logic [WIDTH-1:0] r_result, w_result;
  logic [WIDTH-1:0] r_mm_x, w_mm_x;
  logic [WIDTH-1:0] r_mm_y, w_mm_y;
  logic             r_busy, r_done, r_mm_rst;
  logic             w_bit, w_idx_zero;

  assign w_bit      = r_exp[r_idx];
  assign w_idx_zero = (r_idx == '0);

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (start) w_next = SCAN;
      SCAN:  if (w_bit || w_idx_zero) w_next = ISSUE;
      ISSUE: w_next = WAIT;
      WAIT: begin
        if (mm_finish) begin
          if (r_op == FROM) w_next = DONE;
          else              w_next = ISSUE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath next values: operand latch, bit scan, operand select, result capture.
  always_comb begin
    w_op     = r_op;
    w_idx    = r_idx;
    w_top    = r_top;
    w_zero   = r_zero;
    w_exp    = r_exp;
    w_base   = r_base;
    w_r2     = r_r2;
    w_n      = r_n;
    w_abar   = r_abar;
    w_acc    = r_acc;
    w_result = r_result;
    w_mm_x   = r_mm_x;
    w_mm_y   = r_mm_y;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_base = base;
          w_exp  = exp;
          w_n    = n;
          w_r2   = r2;
          w_idx  = IDX_TOP;
          w_zero = 1'b0;
        end
      end
      SCAN: begin
        if (w_bit) begin
          w_top = r_idx;
          w_op  = TOBASE;
        end else if (w_idx_zero) begin
          w_zero = 1'b1;
          w_op   = TOBASE;
        end else begin
          w_idx = r_idx - IDX_W'(1);
        end
      end
      ISSUE: begin
        case (r_op)
          TOBASE:  begin w_mm_x = r_base; w_mm_y = r_r2;   end
          TOONE:   begin w_mm_x = ONE_W;  w_mm_y = r_r2;   end
          SQR:     begin w_mm_x = r_acc;  w_mm_y = r_acc;  end
          MUL:     begin w_mm_x = r_acc;  w_mm_y = r_abar; end
          default: begin w_mm_x = r_acc;  w_mm_y = ONE_W;  end
        endcase
      end
      WAIT: begin
        if (mm_finish) begin
          case (r_op)
            TOBASE: begin
              w_abar = mm_result;
              w_op   = TOONE;
            end
            TOONE: begin
              w_acc = mm_result;
              if (r_zero) begin
                w_op = FROM;
              end else begin
                w_op  = SQR;
                w_idx = r_top;
              end
            end
            SQR: begin
              w_acc = mm_result;
              if (w_bit) begin
                w_op = MUL;
              end else if (w_idx_zero) begin
                w_op = FROM;
              end else begin
                w_op  = SQR;
                w_idx = r_idx - IDX_W'(1);
              end
            end
            MUL: begin
              w_acc = mm_result;
              if (w_idx_zero) begin
                w_op = FROM;
              end else begin
                w_op  = SQR;
                w_idx = r_idx - IDX_W'(1);
              end
            end
            default: w_result = mm_result;
          endcase
        end
      end
      default: ;
    endcase
  end

  // Status outputs are registered from the next state so they align with it.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_op     <= TOBASE;
      r_idx    <= '0;
      r_top    <= '0;
      r_zero   <= 1'b0;
      r_exp    <= '0;
      r_base   <= '0;
      r_r2     <= '0;
      r_n      <= '0;
      r_abar   <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_mm_x   <= '0;
      r_mm_y   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_mm_rst <= 1'b1;
    end else begin
      r_op     <= w_op;
      r_idx    <= w_idx;
      r_top    <= w_top;
      r_zero   <= w_zero;
      r_exp    <= w_exp;
      r_base   <= w_base;
      r_r2     <= w_r2;
      r_n      <= w_n;
      r_abar   <= w_abar;
      r_acc    <= w_acc;
      r_result <= w_result;
      r_mm_x   <= w_mm_x;
      r_mm_y   <= w_mm_y;
      r_busy   <= (w_next != IDLE);
      r_done   <= (w_next == DONE);
      r_mm_rst <= (w_next != WAIT);
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign mm_x   = r_mm_x;
  assign mm_y   = r_mm_y;
  assign mm_n   = r_n;
  assign mm_rst = r_mm_rst;

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Randomized bench for mod_exp_ctrl: behavioural Montgomery multiplier beside the DUT,
// results checked against plain modular exponentiation.
module tb_mod_exp_ctrl;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned EXP_W = 8;
  localparam int K_TOBASE = 0;
  localparam int K_TOONE  = 1;
  localparam int K_SQR    = 2;
  localparam int K_MUL    = 3;
  localparam int K_FROM   = 4;

  typedef logic [WIDTH-1:0] word_t;

  logic             clk = 1'b0;
  logic             sys_rst, start;
  word_t            base, n, r2, result, mm_x, mm_y, mm_n, mm_result;
  logic [EXP_W-1:0] exp;
  logic             busy, done, mm_rst, mm_finish;

  mod_exp_ctrl #(.WIDTH(WIDTH), .EXP_W(EXP_W)) dut (
    .clk       (clk),
    .sys_rst   (sys_rst),
    .start     (start),
    .base      (base),
    .exp       (exp),
    .n         (n),
    .r2        (r2),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .mm_x      (mm_x),
    .mm_y      (mm_y),
    .mm_n      (mm_n),
    .mm_rst    (mm_rst),
    .mm_finish (mm_finish),
    .mm_result (mm_result)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input word_t got, input word_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // a*b*2^-WIDTH mod nn by bitwise Montgomery reduction of the full product.
  function automatic word_t mm_ref(input word_t a, input word_t b, input word_t nn);
    logic [2*WIDTH+1:0] t;
    t = (2*WIDTH+2)'(a) * (2*WIDTH+2)'(b);
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (t[0]) t = t + (2*WIDTH+2)'(nn);
      t = t >> 1;
    end
    if (t >= (2*WIDTH+2)'(nn)) t = t - (2*WIDTH+2)'(nn);
    return WIDTH'(t);
  endfunction

  function automatic word_t r2_ref(input word_t nn);
    logic [WIDTH:0] x;
    x = (WIDTH+1)'(1);
    for (int i = 0; i < int'(2*WIDTH); i++) begin
      x = x << 1;
      if (x >= (WIDTH+1)'(nn)) x = x - (WIDTH+1)'(nn);
    end
    return WIDTH'(x);
  endfunction

  function automatic word_t modexp_ref(input word_t b, input logic [EXP_W-1:0] e, input word_t nn);
    logic [2*WIDTH-1:0] r, bb, nw;
    nw = (2*WIDTH)'(nn);
    bb = (2*WIDTH)'(b) % nw;
    r  = (2*WIDTH)'(1) % nw;
    for (int i = int'(EXP_W) - 1; i >= 0; i--) begin
      r = (r * r) % nw;
      if (e[i]) r = (r * bb) % nw;
    end
    return WIDTH'(r);
  endfunction

  // Multiplier model: finishes after wlat cycles of mm_rst low, holds finish until relaunched.
  logic  fin_model = 1'b0;
  logic  force_fin = 1'b0;
  word_t mm_res    = '0;
  int    wcnt      = 0;
  int    wlat      = 2;
  int    w_fixed   = 0;

  assign mm_finish = fin_model | force_fin;
  assign mm_result = mm_res;

  always @(posedge clk) begin
    if (mm_rst) begin
      wcnt      <= 0;
      fin_model <= 1'b0;
      wlat      <= (w_fixed != 0) ? w_fixed : int'($urandom_range(6, 2));
    end else begin
      wcnt <= wcnt + 1;
      if (wcnt == wlat - 2) begin
        fin_model <= 1'b1;
        mm_res    <= mm_ref(mm_x, mm_y, mm_n);
      end
    end
  end

  // Expected operation schedule and Montgomery-domain values.
  int    sched[$];
  int    n_launch = 0;
  word_t m_base, m_r2, m_n;
  word_t m_abar = '0;
  word_t m_acc  = '0;

  initial begin : mon
    logic  prev_rst;
    int    op;
    word_t ex, ey, p;
    prev_rst = 1'b1;
    forever begin
      @(negedge clk);
      if (!mm_rst && prev_rst) begin
        n_launch++;
        chk("op_pending", word_t'(sched.size() > 0), word_t'(1));
        if (sched.size() > 0) begin
          op = sched.pop_front();
          case (op)
            K_TOBASE: begin ex = m_base; ey = m_r2;   end
            K_TOONE:  begin ex = 1;      ey = m_r2;   end
            K_SQR:    begin ex = m_acc;  ey = m_acc;  end
            K_MUL:    begin ex = m_acc;  ey = m_abar; end
            default:  begin ex = m_acc;  ey = 1;      end
          endcase
          chk("mm_x", mm_x, ex);
          chk("mm_y", mm_y, ey);
          chk("mm_n", mm_n, m_n);
          p = mm_ref(ex, ey, m_n);
          if (op == K_TOBASE)    m_abar = p;
          else if (op != K_FROM) m_acc  = p;
        end
      end
      prev_rst = mm_rst;
    end
  end

  // inject: 0 plain run, 1 stray start and mm_finish while busy, 2 reset in third op's WAIT.
  task automatic run(input word_t b, input logic [EXP_W-1:0] e, input word_t nn,
                     input int wfix, input int inject, input string tag);
    word_t rr2, want;
    int    top, scan, nops, cyc, lowc, launch0;
    bit    seen;
    rr2 = r2_ref(nn);
    want = modexp_ref(b, e, nn);
    sched.delete();
    sched.push_back(K_TOBASE);
    sched.push_back(K_TOONE);
    top = -1;
    for (int i = int'(EXP_W) - 1; i >= 0; i--) if (e[i] && top < 0) top = i;
    for (int i = top; i >= 0; i--) begin
      sched.push_back(K_SQR);
      if (e[i]) sched.push_back(K_MUL);
    end
    sched.push_back(K_FROM);
    nops = sched.size();
    scan = (top < 0) ? int'(EXP_W) : int'(EXP_W) - top;
    m_base = b; m_r2 = rr2; m_n = nn;
    w_fixed = wfix;
    @(negedge clk);
    launch0 = n_launch;
    base = b; exp = e; n = nn; r2 = rr2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    base = word_t'({$urandom, $urandom});
    exp  = EXP_W'($urandom);
    n    = word_t'({$urandom, $urandom});
    r2   = word_t'({$urandom, $urandom});
    cyc = 1; lowc = 0; seen = 1'b0;
    chk({tag, "_busy_start"}, word_t'(busy), word_t'(1));
    while (!seen && cyc < 4000) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (!mm_rst) lowc++;
        if (inject == 1) begin
          force_fin = (cyc >= 1 && cyc <= 3);
          start     = (cyc == 20);
        end
        if (inject == 2 && (n_launch - launch0) == 3 && !mm_rst) begin
          sys_rst = 1'b1;
          #1;
          chk({tag, "_rst_state"}, word_t'(dut.r_state), word_t'(mod_exp_pkg::IDLE));
          chk({tag, "_rst_mm_rst"}, word_t'(mm_rst), word_t'(1));
          chk({tag, "_rst_busy"}, word_t'(busy), word_t'(0));
          chk({tag, "_rst_done"}, word_t'(done), word_t'(0));
          chk({tag, "_rst_result"}, result, word_t'(0));
          @(negedge clk);
          sys_rst = 1'b0;
          sched.delete();
          repeat (4) begin
            @(negedge clk);
            if (done) seen = 1'b1;
          end
          chk({tag, "_no_done"}, word_t'(seen), word_t'(0));
          chk({tag, "_idle_busy"}, word_t'(busy), word_t'(0));
          w_fixed = 0;
          return;
        end
        @(negedge clk);
        cyc++;
      end
    end
    force_fin = 1'b0;
    start = 1'b0;
    chk({tag, "_done_seen"}, word_t'(seen), word_t'(1));
    if (seen) begin
      chk({tag, "_result"}, result, want);
      chk({tag, "_ops"}, word_t'(n_launch - launch0), word_t'(nops));
      chk({tag, "_sched_left"}, word_t'(sched.size()), word_t'(0));
      if (wfix != 0) begin
        chk({tag, "_latency"}, word_t'(cyc + 1), word_t'(1 + scan + nops * (1 + wfix) + 1));
        chk({tag, "_mm_rst_low"}, word_t'(lowc), word_t'(nops * wfix));
      end
      @(negedge clk);
      chk({tag, "_busy_after"}, word_t'(busy), word_t'(0));
      chk({tag, "_done_once"}, word_t'(done), word_t'(0));
      chk({tag, "_result_held"}, result, want);
    end
    w_fixed = 0;
  endtask

  initial begin
    sys_rst = 1'b1; start = 1'b0;
    base = '0; exp = '0; n = '0; r2 = '0;
    repeat (2) @(negedge clk);
    chk("reset_state", word_t'(dut.r_state), word_t'(mod_exp_pkg::IDLE));
    chk("reset_busy", word_t'(busy), word_t'(0));
    chk("reset_done", word_t'(done), word_t'(0));
    chk("reset_mm_rst", word_t'(mm_rst), word_t'(1));
    chk("reset_result", result, word_t'(0));
    chk("reset_mm_x", mm_x, word_t'(0));
    chk("reset_mm_y", mm_y, word_t'(0));
    chk("reset_mm_n", mm_n, word_t'(0));
    sys_rst = 1'b0;

    run(64'd4, 8'd13, 64'd497, 0, 0, "vec13");
    chk("vec13_known", result, word_t'(445));
    run(64'd4, 8'd0, 64'd497, 0, 0, "exp0");
    chk("exp0_known", result, word_t'(1));
    run(64'd953213471, 8'd1, 64'd9561345678456161, 0, 0, "exp1");
    chk("exp1_known", result, word_t'(953213471));
    run(64'd123456789, 8'b0000_1011, 64'd9561345678456161, 10, 0, "lat");
    run(64'd77, 8'h05, 64'd1000003, 0, 1, "ignore");
    run(64'd31337, 8'hb7, 64'd1000003, 6, 2, "midrst");
    run(64'd4, 8'd13, 64'd497, 0, 0, "after_rst");

    for (int i = 0; i < 14; i++) begin
      word_t rn, rb;
      logic [EXP_W-1:0] re;
      rn = word_t'({$urandom, $urandom}) >> ((i % 4) * 12);
      rn = rn | word_t'(1);
      if (rn < 3) rn = 3;
      rb = word_t'({$urandom, $urandom}) % rn;
      re = EXP_W'($urandom);
      if (i == 0) re = '0;
      if (i == 1) re = '1;
      if (i == 2) re = EXP_W'(8'h80);
      if (i == 3) re = EXP_W'(1);
      run(rb, re, rn, (i == 5) ? 3 : 0, 0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_exp_ctrl.md
# mod_exp_ctrl

Sequencer that computes result = base^exp mod n by driving the shared MONT_MUL Montgomery multiplier through a left-to-right square-and-multiply schedule. It sits between the RSA top level and MONT_MUL. It owns the multiplier's operand, modulus and reset inputs, and observes mm_finish/result. Operands are latched at start, so the caller may change its inputs while the block is busy.

## Interface
Parameters:
- WIDTH, 2048, operand/modulus width; must equal the MONT_MUL width
- EXP_W, 2048, exponent width

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock, rising edge
- sys_rst  in  1  asynchronous active-high reset
- start  in  1  request pulse; accepted only in IDLE
- base  in  WIDTH  message/base, must be < n
- exp  in  EXP_W  exponent
- n  in  WIDTH  odd modulus
- r2  in  WIDTH  R^2 mod n, with R = 2^WIDTH; precomputed by the caller
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse; result valid in the same cycle
- result  out  WIDTH  base^exp mod n; held until the next done
- mm_x, mm_y  out  WIDTH  multiplier operands, registered
- mm_n  out  WIDTH  latched modulus
- mm_rst  out  1  multiplier reset/launch; the multiplier runs only while this is low
- mm_finish  in  1  multiplier completion level
- mm_result  in  WIDTH  multiplier output, valid while mm_finish is high

## Operation
- Montgomery product: MM(a,b) = a·b·R^-1 mod n.
- Schedule of operations:
  - TOBASE: abar = MM(base, r2)
  - TOONE: acc = MM(1, r2), giving R mod n
  - For each bit i, from the top set bit of exp down to 0:
    - SQR: acc = MM(acc, acc)
    - if exp[i] = 1, MUL: acc = MM(acc, abar)
  - FROM: result = MM(acc, 1)
- States:
  - IDLE: mm_rst = 1. On start, latch base/exp/n/r2, set idx = EXP_W-1, go to SCAN.
  - SCAN: one cycle per examined bit.
    - If exp[idx] = 1, record top = idx and go to ISSUE with op TOBASE.
    - Else if idx = 0, set the zero-exponent flag and go to ISSUE with op TOBASE.
    - Else decrement idx.
  - ISSUE: one cycle. mm_rst = 1, mm_x/mm_y loaded for the current op. Go to WAIT.
  - WAIT: mm_rst = 0. On mm_finish = 1, capture mm_result into abar, acc or result according to op, then pick the next op (or go to DONE).
  - DONE: one cycle. done = 1. Return to IDLE.
- Next-op rules after capture:
  - TOBASE goes to TOONE.
  - TOONE goes to FROM if the zero-exponent flag is set, else to SQR at idx = top.
  - SQR goes to MUL if exp[idx] = 1; otherwise, if idx = 0, to FROM; else decrement idx and go to SQR.
  - MUL goes to FROM if idx = 0; else decrement idx and go to SQR.
  - After FROM, go to DONE.
- exp = 0 yields result = 1 (for n > 1) using exactly 3 multiplications.
- start while busy is ignored. mm_finish outside WAIT is ignored.
- Width rule: the constant 1 is zero-extended to WIDTH. No arithmetic is done in this block other than idx decrement and compare.

## Timing
- Reset values:
  - state = IDLE
  - busy = 0, done = 0
  - mm_rst = 1
  - result, mm_x, mm_y, mm_n = 0
- sys_rst mid-operation: immediate return to IDLE with mm_rst = 1. The partial computation is discarded, no done is issued, and result is reset to 0.
- Each multiplication costs 1 ISSUE cycle plus W WAIT cycles, where W counts WAIT cycles up to and including the cycle mm_finish is sampled high.
- ISSUE holding mm_rst high guarantees that a stale mm_finish from the previous op is cleared before WAIT.
- Total latency from start to done:
  - 1 + (EXP_W − top) SCAN cycles + (number of ops) × (1 + W) + 1 DONE cycle
  - number of ops = 3 + (top + 1) + popcount(exp)
  - for exp = 0, SCAN takes EXP_W cycles and number of ops = 3
- The new start is accepted in IDLE the cycle after DONE.

## Structure
- Package mod_exp_pkg holds:
  - state enum: IDLE, SCAN, ISSUE, WAIT, DONE
  - op enum: TOBASE, TOONE, SQR, MUL, FROM
  - the MM_ONE constant
- No sub-module. MONT_MUL is instantiated beside this block by the parent, not inside it.
- The leading-zero scan stays inline, sequential, one bit per cycle.

## Test plan
- WIDTH = 2048, n = 497, base = 4, exp = 13, r2 = 2^4096 mod 497, real MONT_MUL → result = 445; op sequence TOBASE, TOONE, SQR, MUL, SQR, MUL, SQR, SQR, MUL, FROM; done pulses exactly once.
- exp = 0, base = 4, n = 497 → result = 1 after 3 ops; busy low the cycle after done.
- exp = 1, base = 953213471, n = 9561345678456161 → result = 953213471 after 5 ops.
- Behavioural MM model with fixed W = 10, exp = 0b1011 with EXP_W = 8 → done exactly 1 + 5 + 10·11 + 1 = 117 cycles after start; mm_rst is high only in ISSUE, IDLE, SCAN and DONE.
- start pulsed again at cycle 20 of a run, and mm_finish forced high during SCAN → both ignored; result unchanged and correct.
- sys_rst asserted mid-WAIT of the third op → next cycle state = IDLE, mm_rst = 1, busy = 0, no done; a fresh start then completes correctly.
